// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - Arbitrates fetch and MEM-stage accesses onto one shared memory port.
module mem_port_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        dm_cs,
    output logic        dm_we,
    output logic [15:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [2:0]  starve_cnt, starve_n;
    logic        dm_cs_n, dm_we_n, if_ack_n, mem_ack_n;
    logic [15:0] dm_addr_n;
    logic [31:0] dm_wdata_n, if_rdata_n, mem_rdata_n;
    logic        if_valid, mem_valid, if_wins;

    // A requester that is being acked this cycle may still show req; it is not a new request.
    assign if_valid  = if_req & ~if_ack;
    assign mem_valid = mem_req & ~mem_ack;
    assign if_wins   = if_valid & (~mem_valid | (starve_cnt == 3'(STARVE_MAX)));

    assign stall_if  = rst & if_req & ~if_ack;
    assign stall_mem = rst & mem_req & ~mem_ack;

    always_comb begin
        state_n     = state;
        starve_n    = starve_cnt;
        dm_cs_n     = dm_cs;
        dm_we_n     = dm_we;
        dm_addr_n   = dm_addr;
        dm_wdata_n  = dm_wdata;
        if_rdata_n  = if_rdata;
        mem_rdata_n = mem_rdata;
        if_ack_n    = 1'b0;
        mem_ack_n   = 1'b0;
        case (state)
            IDLE: begin
                if (if_wins) begin
                    state_n    = GNT_IF;
                    dm_cs_n    = 1'b1;
                    dm_we_n    = 1'b0;
                    dm_addr_n  = if_addr;
                    dm_wdata_n = 32'd0;
                    starve_n   = 3'd0;
                end else if (mem_valid) begin
                    state_n    = GNT_MEM;
                    dm_cs_n    = 1'b1;
                    dm_we_n    = mem_we;
                    dm_addr_n  = mem_addr;
                    dm_wdata_n = mem_wdata;
                    if (if_valid && (starve_cnt < 3'(STARVE_MAX)))
                        starve_n = starve_cnt + 3'd1;
                end
            end
            GNT_IF: begin
                if (dm_ready) begin
                    state_n    = IDLE;
                    dm_cs_n    = 1'b0;
                    if_ack_n   = 1'b1;
                    if_rdata_n = dm_rdata;
                end
            end
            GNT_MEM: begin
                if (dm_ready) begin
                    state_n   = IDLE;
                    dm_cs_n   = 1'b0;
                    mem_ack_n = 1'b1;
                    if (!dm_we)
                        mem_rdata_n = dm_rdata;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            dm_cs      <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= 16'd0;
            dm_wdata   <= 32'd0;
            if_rdata   <= 32'd0;
            mem_rdata  <= 32'd0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            dm_cs      <= dm_cs_n;
            dm_we      <= dm_we_n;
            dm_addr    <= dm_addr_n;
            dm_wdata   <= dm_wdata_n;
            if_rdata   <= if_rdata_n;
            mem_rdata  <= mem_rdata_n;
            if_ack     <= if_ack_n;
            mem_ack    <= mem_ack_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - Directed and randomized checks of mem_port_arb against a reference model.
module tb_mem_port_arb;

    localparam int STARVE = 4;

    logic        clk;
    logic        rst;
    logic        if_req, mem_req, mem_we, dm_ready;
    logic [15:0] if_addr, mem_addr;
    logic [31:0] mem_wdata, dm_rdata;
    logic [31:0] if_rdata, mem_rdata, dm_wdata;
    logic        if_ack, mem_ack, dm_cs, dm_we, stall_if, stall_mem;
    logic [15:0] dm_addr;

    mem_port_arb #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dm_cs(dm_cs), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 MEM) and what the bus shows.
    int          m_owner, m_starve;
    logic        m_cs, m_we, m_if_ack, m_mem_ack;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_if_rdata, m_mem_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_starve = 0;
        m_cs = 1'b0; m_we = 1'b0; m_addr = 16'd0; m_wdata = 32'd0;
        m_if_ack = 1'b0; m_mem_ack = 1'b0; m_if_rdata = 32'd0; m_mem_rdata = 32'd0;
    endtask

    task automatic check_all();
        chk("dm_cs", 32'(dm_cs), 32'(m_cs));
        chk("dm_we", 32'(dm_we), 32'(m_we));
        chk("dm_addr", 32'(dm_addr), 32'(m_addr));
        chk("dm_wdata", dm_wdata, m_wdata);
        chk("if_ack", 32'(if_ack), 32'(m_if_ack));
        chk("mem_ack", 32'(mem_ack), 32'(m_mem_ack));
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("mem_rdata", mem_rdata, m_mem_rdata);
        chk("stall_if", 32'(stall_if), 32'(rst & if_req & ~m_if_ack));
        chk("stall_mem", 32'(stall_mem), 32'(rst & mem_req & ~m_mem_ack));
        chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
    endtask

    // Evaluate the arbitration rules on the pre-edge inputs, then advance one clock.
    task automatic tick();
        int          n_owner, n_starve;
        logic        n_cs, n_we, n_if_ack, n_mem_ack, if_v, mem_v;
        logic [15:0] n_addr;
        logic [31:0] n_wdata, n_if_rdata, n_mem_rdata;
        if_v  = if_req & ~m_if_ack;
        mem_v = mem_req & ~m_mem_ack;
        n_owner = m_owner; n_starve = m_starve; n_cs = m_cs; n_we = m_we;
        n_addr = m_addr; n_wdata = m_wdata; n_if_rdata = m_if_rdata; n_mem_rdata = m_mem_rdata;
        n_if_ack = 1'b0; n_mem_ack = 1'b0;
        if (m_owner == 0) begin
            if (if_v && (!mem_v || m_starve == STARVE)) begin
                n_owner = 1; n_cs = 1'b1; n_we = 1'b0; n_addr = if_addr; n_wdata = 32'd0;
                n_starve = 0;
            end else if (mem_v) begin
                n_owner = 2; n_cs = 1'b1; n_we = mem_we; n_addr = mem_addr; n_wdata = mem_wdata;
                if (if_v) n_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
            end
        end else if (dm_ready) begin
            if (m_owner == 1) begin
                n_if_ack = 1'b1; n_if_rdata = dm_rdata;
            end else begin
                n_mem_ack = 1'b1;
                if (!m_we) n_mem_rdata = dm_rdata;
            end
            n_owner = 0; n_cs = 1'b0;
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_owner = n_owner; m_starve = n_starve; m_cs = n_cs; m_we = n_we;
            m_addr = n_addr; m_wdata = n_wdata; m_if_ack = n_if_ack; m_mem_ack = n_mem_ack;
            m_if_rdata = n_if_rdata; m_mem_rdata = n_mem_rdata;
        end
        #1;
        check_all();
    endtask

    logic if_linger, mem_linger;
    int   ack_cnt;

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = 16'd0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = 16'd0; mem_wdata = 32'd0; dm_ready = 1'b0; dm_rdata = 32'd0;
        if_linger = 1'b0; mem_linger = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("reset_dm_cs", 32'(dm_cs), 32'd0);
        rst = 1'b1;

        // Fetch read completing with zero wait states
        if_req = 1'b1; if_addr = 16'h0010; dm_ready = 1'b1; dm_rdata = 32'hDEADBEEF;
        tick();
        chk("if_rd_cs", 32'(dm_cs), 32'd1);
        chk("if_rd_addr", 32'(dm_addr), 32'h0010);
        tick();
        chk("if_rd_cs_drop", 32'(dm_cs), 32'd0);
        chk("if_rd_ack", 32'(if_ack), 32'd1);
        chk("if_rd_data", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();
        chk("if_rd_ack_once", 32'(if_ack), 32'd0);

        // Simultaneous requests: store goes first, fetch follows in the ack cycle
        if_req = 1'b1; if_addr = 16'h0040;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0200; mem_wdata = 32'h12345678;
        dm_rdata = 32'hA5A5A5A5;
        tick();
        chk("both_mem_first_we", 32'(dm_we), 32'd1);
        chk("both_mem_addr", 32'(dm_addr), 32'h0200);
        chk("both_mem_wdata", dm_wdata, 32'h12345678);
        tick();
        chk("both_mem_ack", 32'(mem_ack), 32'd1);
        chk("both_mem_rdata_kept", mem_rdata, 32'd0);
        chk("both_if_rdata_kept", if_rdata, 32'hDEADBEEF);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        chk("both_if_next_addr", 32'(dm_addr), 32'h0040);
        chk("both_if_next_we", 32'(dm_we), 32'd0);
        tick();
        chk("both_if_rdata", if_rdata, 32'hA5A5A5A5);
        if_req = 1'b0;
        tick();

        // MEM keeps winning while fetch contends; fetch steps aside only in MEM ack cycles
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0300;
        if_req = 1'b1; if_addr = 16'h0050;
        for (int g = 0; g < STARVE; g++) begin
            tick();
            chk("starve_mem_grant", 32'(dm_addr), 32'h0300);
            chk("starve_count", 32'(dut.starve_cnt), 32'(g + 1));
            tick();
            if_req = 1'b0;
            tick();
            if_req = 1'b1;
        end
        tick();
        chk("starve_if_wins", 32'(dm_addr), 32'h0050);
        chk("starve_cleared", 32'(dut.starve_cnt), 32'd0);
        tick();
        if_req = 1'b0; mem_req = 1'b0;
        tick();

        // Five wait states on a MEM load
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0444; dm_ready = 1'b0;
        ack_cnt = 0;
        tick();
        for (int w = 0; w < 5; w++) begin
            tick();
            chk("wait_cs", 32'(dm_cs), 32'd1);
            chk("wait_addr", 32'(dm_addr), 32'h0444);
            chk("wait_stall", 32'(stall_mem), 32'd1);
            ack_cnt += int'(mem_ack);
        end
        dm_ready = 1'b1; dm_rdata = 32'h0BADF00D;
        tick();
        ack_cnt += int'(mem_ack);
        chk("wait_rdata", mem_rdata, 32'h0BADF00D);
        mem_req = 1'b0;
        tick();
        ack_cnt += int'(mem_ack);
        chk("wait_one_ack", 32'(ack_cnt), 32'd1);

        // Reset during a fetch grant abandons it; held request is granted again after release
        if_req = 1'b1; if_addr = 16'h0060; dm_ready = 1'b0;
        tick();
        chk("rst_pre_cs", 32'(dm_cs), 32'd1);
        #3 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_cs", 32'(dm_cs), 32'd0);
        chk("rst_async_mem_rdata", mem_rdata, 32'd0);
        dm_ready = 1'b1;
        tick();
        chk("rst_no_ack", 32'(if_ack), 32'd0);
        #2 rst = 1'b1;
        dm_ready = 1'b0;
        tick();
        chk("rst_regrant_addr", 32'(dm_addr), 32'h0060);
        dm_ready = 1'b1; dm_rdata = 32'h00C0FFEE;
        tick();
        chk("rst_regrant_ack", 32'(if_ack), 32'd1);
        if_req = 1'b0;
        tick();

        // Requester keeps req up through its ack cycle
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0700;
        tick();
        tick();
        chk("linger_ack", 32'(mem_ack), 32'd1);
        tick();
        chk("linger_no_dup", 32'(dm_cs), 32'd0);
        mem_req = 1'b0;
        tick();

        // Randomized traffic with random wait states, lingering reqs and occasional resets
        for (int c = 0; c < 3000; c++) begin
            dm_ready = ($urandom_range(0, 2) != 0);
            dm_rdata = $urandom;
            if (if_ack) begin
                if ($urandom_range(0, 1) == 1) if_linger = 1'b1;
                else if_req = 1'b0;
            end else if (if_linger) begin
                if_req = 1'b0; if_linger = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 16'($urandom);
            end
            if (mem_ack) begin
                if ($urandom_range(0, 1) == 1) mem_linger = 1'b1;
                else mem_req = 1'b0;
            end else if (mem_linger) begin
                mem_req = 1'b0; mem_linger = 1'b0;
            end else if (!mem_req && $urandom_range(0, 1) == 0) begin
                mem_req = 1'b1; mem_we = 1'($urandom);
                mem_addr = 16'($urandom); mem_wdata = $urandom;
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                if_linger = 1'b0; mem_linger = 1'b0;
                #1;
                check_all();
                #2 rst = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
